// File: rtl/data_1_2.sv
// Header-steered packet router: one ap_vld/ap_ack input stream, two outputs.
// Header word picks the destination and payload length; payload is forwarded.
module data_1_2 #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 16,
    parameter int DEST_BIT   = 31
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [DATA_WIDTH-1:0] Input_1_V_V,
    input  logic                  Input_1_V_V_ap_vld,
    output logic                  Input_1_V_V_ap_ack,
    output logic [DATA_WIDTH-1:0] Output_1_V_V,
    output logic                  Output_1_V_V_ap_vld,
    input  logic                  Output_1_V_V_ap_ack,
    output logic [DATA_WIDTH-1:0] Output_2_V_V,
    output logic                  Output_2_V_V_ap_vld,
    input  logic                  Output_2_V_V_ap_ack
);

    localparam logic [0:0] HDR = 1'b0;
    localparam logic [0:0] PAY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  dest_q, dest_d;
    logic [LEN_BITS-1:0]   rem_q, rem_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] o1_data_q, o1_data_d;
    logic [DATA_WIDTH-1:0] o2_data_q, o2_data_d;
    logic                  o1_vld_q, o1_vld_d;
    logic                  o2_vld_q, o2_vld_d;
    logic                  in_ack, xfer, ld1, ld2;
    logic [LEN_BITS-1:0]   hdr_len;

    assign hdr_len = Input_1_V_V[LEN_BITS-1:0];

    // In PAY the input only stalls when the selected output cannot drain.
    always_comb begin
        in_ack = ap_start;
        if (state_q == PAY) begin
            if (dest_q) in_ack = !o2_vld_q || Output_2_V_V_ap_ack;
            else        in_ack = !o1_vld_q || Output_1_V_V_ap_ack;
        end
    end

    assign xfer = Input_1_V_V_ap_vld && in_ack;

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        ld1     = 1'b0;
        ld2     = 1'b0;
        case (state_q)
            HDR: begin
                if (xfer) begin
                    dest_d = Input_1_V_V[DEST_BIT];
                    rem_d  = hdr_len;
                    if (hdr_len == '0) done_d  = 1'b1;
                    else               state_d = PAY;
                end
            end
            PAY: begin
                if (xfer) begin
                    ld1   = !dest_q;
                    ld2   = dest_q;
                    rem_d = rem_q - LEN_BITS'(1);
                    if (rem_q == LEN_BITS'(1)) begin
                        done_d  = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        o1_vld_d  = ld1 || (o1_vld_q && !Output_1_V_V_ap_ack);
        o2_vld_d  = ld2 || (o2_vld_q && !Output_2_V_V_ap_ack);
        o1_data_d = ld1 ? Input_1_V_V : o1_data_q;
        o2_data_d = ld2 ? Input_1_V_V : o2_data_q;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= HDR;
            dest_q    <= 1'b0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            o1_vld_q  <= 1'b0;
            o2_vld_q  <= 1'b0;
            o1_data_q <= '0;
            o2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            o1_vld_q  <= o1_vld_d;
            o2_vld_q  <= o2_vld_d;
            o1_data_q <= o1_data_d;
            o2_data_q <= o2_data_d;
        end
    end

    assign Input_1_V_V_ap_ack  = in_ack;
    assign Output_1_V_V        = o1_data_q;
    assign Output_1_V_V_ap_vld = o1_vld_q;
    assign Output_2_V_V        = o2_data_q;
    assign Output_2_V_V_ap_vld = o2_vld_q;
    assign ap_done             = done_q;
    assign ap_ready            = done_q;
    assign ap_idle             = (state_q == HDR) && !o1_vld_q && !o2_vld_q;

endmodule

// File: doc/data_1_2.md
# data_1_2

Single-input, dual-output user operator for a PR-flow leaf. It consumes one 32-bit ap_vld/ap_ack stream from the leaf interface's user-side output and steers each packet to one of two output streams that feed the leaf interface's user-side inputs. The operator is an RTL-native counterpart to the HLS operators, with the same ap_* control and stream port conventions, so the leaf wrapper instantiates it the same way. Each packet is a header word followed by N payload words. The header selects the destination.

## Interface
- DATA_WIDTH, 32, stream word width
- LEN_BITS, 16, width of header length field; header[LEN_BITS-1:0] = N payload words
- DEST_BIT, 31, header bit selecting destination (0 → Output_1, 1 → Output_2)

- ap_clk  in  1  single clock; all state on rising edge
- ap_rst  in  1  asynchronous, active-high reset
- ap_start  in  1  when low, no new header is accepted
- ap_done  out  1  one-cycle pulse at packet completion
- ap_idle  out  1  high when in HDR with both output registers empty
- ap_ready  out  1  identical to ap_done
- Input_1_V_V  in  DATA_WIDTH  input word
- Input_1_V_V_ap_vld  in  1  input word valid
- Input_1_V_V_ap_ack  out  1  input word accepted (combinational)
- Output_1_V_V / Output_2_V_V  out  DATA_WIDTH  output words (registered)
- Output_1_V_V_ap_vld / Output_2_V_V_ap_vld  out  1  output valid (registered)
- Output_1_V_V_ap_ack / Output_2_V_V_ap_ack  in  1  downstream accept

## Operation
- Transfer rule on every stream: a word moves at a rising edge where vld=1 and ack=1. A producer holds data and vld stable until that edge.
- FSM has 2 states: HDR and PAY. Registers are `dest` (1 bit) and `remaining` (LEN_BITS).
- HDR state:
  - Input ack = ap_start.
  - On a header transfer: dest ← header[DEST_BIT] and remaining ← header[LEN_BITS-1:0].
  - If N≠0, go to PAY. If N=0, pulse ap_done/ap_ready and stay in HDR.
  - The header word is never forwarded.
- PAY state:
  - Input ack = (!out_vld[dest] || out_ack[dest]). The ack ignores ap_start.
  - On a transfer, the word loads the dest output register (vld←1) and remaining decrements.
  - When the transfer has remaining==1, pulse ap_done/ap_ready and return to HDR.
- Each output register is a one-entry buffer:
  - vld clears on its ack when no load happens in the same cycle.
  - Simultaneous drain and load keeps vld=1 with the new data, giving full throughput.
  - The non-selected output is never loaded.
- Output registers drain independently of FSM state and of ap_start.
- ap_idle = (state==HDR) && !Output_1 vld && !Output_2 vld.
- Length arithmetic is unsigned modulo 2^LEN_BITS. The maximum packet length is 2^LEN_BITS−1 payload words.
- Header bits other than DEST_BIT and [LEN_BITS-1:0] are ignored.

## Timing
- Reset (async assert, deassert synchronous to ap_clk): state=HDR, remaining=0, dest=0, both Output vld=0, both Output data=0, ap_done=ap_ready=0, ap_idle=1.
- Header latency: a header accepted at edge k allows payload accept at edge k+1 at the earliest.
- Payload latency: a word accepted at edge k is visible on Output_x with vld=1 during cycle k+1 (one register).
- Throughput: 1 payload word per cycle with downstream ack held high. Each packet costs 1 extra cycle for the header.
- ap_done/ap_ready are registered and high for exactly the cycle after the completing transfer edge.
- Backpressure: with the dest output full and its ack=0, input ack=0 and the input word must be held.
- Reset mid-packet: the partial packet is discarded and both output registers are cleared. The next word after reset is treated as a header.
- Input vld=0 in PAY: the FSM waits indefinitely and remaining is unchanged.

## Test plan
- Header 0x0000_0003, then payload 0xA, 0xB, 0xC with acks held 1 → Output_1 carries 0xA, 0xB, 0xC on 3 consecutive cycles. Output_2 vld stays 0. ap_done pulses once, one cycle after 0xC is accepted.
- Header 0x8000_0002, then 0x11, 0x22, with Output_2 ack=0 for 4 cycles → Output_2 holds 0x11 with vld=1 and input ack=0 for those cycles. After ack rises, 0x22 follows.
- Header 0x8000_0000 (N=0) → no output activity, ap_done pulses, FSM remains in HDR. The next word is parsed as a header.
- ap_start=0 with a header presented → input ack=0 and ap_idle=1. Raising ap_start accepts the header on the next edge.
- Back-to-back packets: dest 0 with N=2, then dest 1 with N=2 → correct steering, no lost or duplicated words, exactly 2 ap_done pulses.
- Assert ap_rst after the 2nd of 5 payload words → outputs go vld=0 immediately (async). The next word 0x8000_0001 is treated as a header, followed by 0x55 appearing on Output_2.
